// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: hex decode, per-digit dp/blanking,
// leading-zero suppression, dead time, PWM brightness and per-frame data snapshots.
module seg_scan_driver #(
   parameter int NUM_DIGITS     = 6,
   parameter int SCAN_DIV       = 25000,
   parameter int DEAD_CYCLES    = 250,
   parameter int BRIGHT_W       = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    lz_en,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   sel,
   output logic [7:0]              seg,
   output logic                    frame_tick
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]    CNT_DEAD = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BRIGHT_W-1:0] PWM_LAST = BRIGHT_W'((1 << BRIGHT_W) - 2);

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BRIGHT_W-1:0]     pwm_ph_q, pwm_ph_d;
   logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic                    sh_lz_q, sh_lz_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic [7:0]              seg_q, seg_d;
   logic                    frame_tick_q, frame_tick_d;

   logic                    slot_end, frame_end, dead, lit, higher_zero, nib_zero;
   logic [3:0]              nib;
   logic [NUM_DIGITS-1:0]   lz_sup;
   logic [NUM_DIGITS-1:0]   sel_act;
   logic [7:0]              seg_act;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_end  = (cnt_q == CNT_LAST);
      frame_end = slot_end && (idx_q == IDX_LAST);
      dead      = (cnt_q < CNT_DEAD);

      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      // Phase 0 lines up with the first active cycle of every slot.
      pwm_ph_d = pwm_ph_q;
      if (cnt_d == CNT_DEAD)  pwm_ph_d = '0;
      else if (!dead)         pwm_ph_d = (pwm_ph_q == PWM_LAST) ? '0 : pwm_ph_q + 1'b1;

      sh_digits_d = sh_digits_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      sh_lz_d     = sh_lz_q;
      if (frame_end) begin
         sh_digits_d = digits;
         sh_dp_d     = dp;
         sh_blank_d  = blank;
         sh_lz_d     = lz_en;
      end

      // Walk from the most significant digit down; digit 0 always shows.
      higher_zero = 1'b1;
      nib_zero    = 1'b0;
      lz_sup      = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nib_zero    = (sh_digits_q[4*i +: 4] == 4'h0);
         lz_sup[i]   = sh_lz_q && higher_zero && nib_zero && (i != 0);
         higher_zero = higher_zero && nib_zero;
      end

      nib = sh_digits_q[4*idx_q +: 4];
      lit = !dead && !sh_blank_q[idx_q] && !lz_sup[idx_q] && (pwm_ph_q < brightness);

      sel_act = '0;
      if (lit) sel_act[idx_q] = 1'b1;
      seg_act = lit ? {sh_dp_q[idx_q], hex7(nib)} : 8'h00;

      sel_d        = SEL_ACTIVE_LOW ? ~sel_act : sel_act;
      seg_d        = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
      frame_tick_d = frame_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pwm_ph_q     <= '0;
         sh_digits_q  <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '1;
         sh_lz_q      <= 1'b0;
         sel_q        <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
         seg_q        <= {8{SEG_ACTIVE_LOW}};
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pwm_ph_q     <= pwm_ph_d;
         sh_digits_q  <= sh_digits_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         sh_lz_q      <= sh_lz_d;
         sel_q        <= sel_d;
         seg_q        <= seg_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign sel        = sel_q;
   assign seg        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scan driver, the next generation of the team's fixed 6-digit decimal scanner. It drives NUM_DIGITS common-select digits from a packed nibble bus. It adds:
- full hex decode with per-digit decimal points,
- per-digit blanking and leading-zero suppression,
- anti-ghosting dead time and PWM brightness control,
- tear-free frame snapshots.

It sits between the clock/counter datapath and the board's digit-select and segment pins.

## Interface
Parameters:
- NUM_DIGITS, 6: digit count, legal range 1..16.
- SCAN_DIV, 25000: clock cycles per digit slot. Must satisfy SCAN_DIV ≥ DEAD_CYCLES + 2.
- DEAD_CYCLES, 250: cycles at the start of each slot with all digits and segments inactive. 0 is legal.
- BRIGHT_W, 4: brightness field width, legal range 1..8.
- SEG_ACTIVE_LOW, 1: 1 drives seg active-low.
- SEL_ACTIVE_LOW, 1: 1 drives sel active-low.

Ports (clock and reset first):
- clk  in  1  system clock; the single clock domain.
- rst  in  1  reset, synchronous and active-high.
- digits  in  4*NUM_DIGITS  packed nibbles; digit i = digits[4i+3:4i]; digit 0 is least significant and rightmost.
- dp  in  NUM_DIGITS  decimal point on, per digit.
- blank  in  NUM_DIGITS  force digit dark, per digit.
- lz_en  in  1  leading-zero suppression enable.
- brightness  in  BRIGHT_W  duty control; 0 = off, all-ones = full on.
- sel  out  NUM_DIGITS  digit select, one-hot active.
- seg  out  8  seg[7] = dp, seg[6:0] = g..a.
- frame_tick  out  1  one-cycle pulse at each frame start.

## Operation
- **Slot counter.** cnt runs 0..SCAN_DIV-1 and wraps. Width is $clog2(SCAN_DIV).
- **Digit index.** idx advances when cnt == SCAN_DIV-1 and wraps from NUM_DIGITS-1 to 0.
- **Snapshot.** On the edge where cnt == SCAN_DIV-1 and idx == NUM_DIGITS-1, shadow registers capture digits, dp, blank and lz_en.
  - All displayed data comes from the shadow registers only.
  - Input changes mid-frame have no effect until the next capture.
  - brightness is not shadowed; it is used live.
- **Decode.** Logical polarity is active-high 1 = lit.
  - Hex 0..F decodes to standard patterns.
  - Reference active-low byte values with dp off: 0→C0, 1→F9, 2→A4, 5→92, 8→80, A→88, F→8E.
  - dp=1 lights seg[7].
- **Digit dark conditions.** Digit i is dark (no sel, no segments) when any of the following holds:
  - its shadow blank bit is 1;
  - lz_en=1, its shadow value is 0, all higher digits are 0, and i ≠ 0. Digit 0 is never suppressed.
- **Dead time.** While cnt < DEAD_CYCLES, sel and seg are all-inactive.
- **PWM.**
  - pwm_ph is a BRIGHT_W-bit counter. It clears at cnt == DEAD_CYCLES and otherwise increments each active cycle, counting 0..2^BRIGHT_W-2 and wrapping (period 2^BRIGHT_W-1).
  - A digit is lit only while pwm_ph < brightness.
  - brightness = 0 keeps the display dark; all-ones keeps it lit for the whole window.
- **Output polarity.** Internal active-high sel and seg are inverted at the output flops per SEL_ACTIVE_LOW and SEG_ACTIVE_LOW.
  - With defaults, idx 0 lit gives sel = 6'b111110.
  - When not lit, sel = all-ones and seg = 8'hFF.

## Timing
- **Output registration.** sel, seg and frame_tick are registered. They reflect the cnt/idx/shadow state of the previous cycle, so latency is 1 cycle.
- **frame_tick.** High for exactly one cycle: the cycle after the capture edge, i.e. when cnt == 0 and idx == 0 are first present. That cycle is always dead or dark, and the new snapshot is displayed from that frame on.
- **Reset state.** While rst is high and on the first edge after it, the design resets to:
  - cnt = 0, idx = 0, pwm_ph = 0;
  - shadow digits = 0, dp = 0, blank = all-ones, lz_en = 0;
  - sel inactive, seg = all-inactive, frame_tick = 0.
- **First frame after reset.** It is fully dark, lasting NUM_DIGITS*SCAN_DIV cycles. The first capture happens at its end.
- **Reset mid-frame.** Takes effect on the next edge. The snapshot is discarded and scanning restarts at idx 0.
- **Simultaneous input change.** An input change on the capture edge is captured. Any later change is held off until the next frame.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=20, DEAD_CYCLES=2, BRIGHT_W=2, defaults otherwise.

1. **Reset.** Hold rst 5 cycles, then release with blank=0.
   - During reset: sel=4'b1111, seg=8'hFF, frame_tick=0.
   - First 80 cycles after release stay dark.
   - frame_tick pulses once at cycle 81.
2. **Decode and scan.** digits=16'h12AF, dp=4'b0001, brightness=3.
   - Slot 0 shows sel=1110, seg=8'h0E for 18 cycles.
   - Slot 1 shows sel=1101, seg=8'h88; slot 2 shows 8'hA4; slot 3 shows 8'hF9.
   - The first 2 cycles of every slot show sel=1111, seg=FF.
3. **Snapshot.** Change digits to 16'h8888 during slot 1.
   - Slots 1–3 are unchanged.
   - After the next frame_tick, all slots show 8'h80.
4. **Leading-zero suppression.**
   - digits=16'h0005, lz_en=1: only slot 0 lit, showing 8'h92.
   - digits=16'h0000, lz_en=1: only slot 0 lit, showing 8'hC0.
   - lz_en=0: all four slots show 8'hC0.
5. **Brightness.**
   - brightness=1: exactly 6 lit cycles per slot, pattern 1-of-3.
   - brightness=0: sel stays 1111, while frame_tick keeps pulsing every 80 cycles.
6. **Reset mid-frame.** Assert rst for 1 cycle during slot 2.
   - Outputs show reset values on the next cycle.
   - Display is dark for a full frame.
   - frame_tick then occurs exactly 80 cycles after rst is released.
